// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan panel driver: 3-plane BCM, 64 columns, 16 row pairs.
// Define HUB75_SCAN_DRIVER_DEADTIME_EN to add DEADTIME blank guards.
module hub75_scan_driver #(
  parameter int BASE_CYCLES = 64,
  parameter int DEADTIME    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] r0,
  input  logic [2:0] g0,
  input  logic [1:0] b0,
  input  logic [2:0] r1,
  input  logic [2:0] g1,
  input  logic [1:0] b1,
  output logic [3:0] row,
  output logic [5:0] col,
  output logic       led_r0,
  output logic       led_g0,
  output logic       led_b0,
  output logic       led_r1,
  output logic       led_g1,
  output logic       led_b1,
  output logic       led_pa1,
  output logic       led_pa2,
  output logic       led_pa3,
  output logic       led_pa4,
  output logic       led_sclk,
  output logic       led_latch,
  output logic       led_blank,
  output logic       frame_start
);

  localparam int CW =
    $clog2((BASE_CYCLES << 2) + DEADTIME + 257);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT     = 3'd1;
  localparam logic [2:0] PRE_BLANK = 3'd2;
  localparam logic [2:0] LATCH     = 3'd3;
  localparam logic [2:0] DISPLAY   = 3'd4;
  localparam logic [2:0] NEXT      = 3'd5;

  localparam logic [CW-1:0] BASE = CW'(BASE_CYCLES);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(255);
`ifdef HUB75_SCAN_DRIVER_DEADTIME_EN
  localparam logic [CW-1:0] PRE_LAST = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] POST = CW'(DEADTIME);
`else
  localparam logic [CW-1:0] PRE_LAST = '0;
  localparam logic [CW-1:0] POST = '0;
`endif

  logic [2:0]    state;
  logic [1:0]    plane;
  logic [CW-1:0] cnt;
  logic [CW-1:0] disp_len;
  logic [CW-1:0] disp_last;
  logic [3:0]    pa;
  logic [2:0]    b0x;
  logic [2:0]    b1x;

  // 2-bit blue is stretched to 3 bits by repeating its MSB
  assign b0x = {b0, b0[1]};
  assign b1x = {b1, b1[1]};

  function automatic logic pbit(
    input logic [2:0] v,
    input logic [1:0] p
  );
    logic [2:0] s;
    s = v >> p;
    return s[0];
  endfunction

  always_comb begin
    disp_len = BASE;
    case (plane)
      2'd1:    disp_len = BASE << 1;
      2'd2:    disp_len = BASE << 2;
      default: disp_len = BASE;
    endcase
    disp_last = disp_len + POST - 1'b1;
  end

  // DISPLAY keeps running through the post-guard with blank high
  assign led_blank =
    !((state == DISPLAY) && (cnt < disp_len));
  assign led_latch = (state == LATCH);
  assign led_sclk =
    (state == SHIFT) && (cnt[1:0] == 2'd3);

  assign led_pa1 = pa[0];
  assign led_pa2 = pa[1];
  assign led_pa3 = pa[2];
  assign led_pa4 = pa[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      plane       <= '0;
      cnt         <= '0;
      pa          <= '0;
      led_r0      <= 1'b0;
      led_g0      <= 1'b0;
      led_b0      <= 1'b0;
      led_r1      <= 1'b0;
      led_g1      <= 1'b0;
      led_b1      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= SHIFT;
            row         <= '0;
            col         <= '0;
            plane       <= '0;
            cnt         <= '0;
            frame_start <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt[1:0] == 2'd1) begin
            led_r0 <= pbit(r0, plane);
            led_g0 <= pbit(g0, plane);
            led_b0 <= pbit(b0x, plane);
            led_r1 <= pbit(r1, plane);
            led_g1 <= pbit(g1, plane);
            led_b1 <= pbit(b1x, plane);
          end
          if (cnt[1:0] == 2'd3) col <= col + 6'd1;
          if (cnt == SHIFT_LAST) begin
            state <= PRE_BLANK;
            cnt   <= '0;
            pa    <= row;
          end
        end
        PRE_BLANK: begin
          if (cnt == PRE_LAST) begin
            state <= LATCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          state <= DISPLAY;
          cnt   <= '0;
        end
        DISPLAY: begin
          if (cnt == disp_last) begin
            state <= NEXT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NEXT: begin
          state <= SHIFT;
          col   <= '0;
          cnt   <= '0;
          if (plane == 2'd2) begin
            plane <= '0;
            row   <= row + 4'd1;
            if (row == 4'd15) begin
              if (enable) frame_start <= 1'b1;
              else state <= IDLE;
            end
          end else begin
            plane <= plane + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: random framebuffer,
// expected per row/plane transactions queued, monitor compares.
module tb_hub75_scan_driver;

  localparam int BASE = 64;
  localparam int DT   = 4;
`ifdef HUB75_SCAN_DRIVER_DEADTIME_EN
  localparam int PRE  = DT;
  localparam int POST = DT;
`else
  localparam int PRE  = 1;
  localparam int POST = 0;
`endif
  localparam int FRAME =
    16 * (3 * (256 + PRE + 1 + 1 + POST) + 7 * BASE);

  typedef struct {
    int          row;
    int          plane;
    int          disp;
    logic [63:0] r0, g0, b0, r1, g1, b1;
  } exp_t;

  logic clk = 0;
  logic rst, enable;
  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;
  logic [3:0] row;
  logic [5:0] col;
  logic led_r0, led_g0, led_b0;
  logic led_r1, led_g1, led_b1;
  logic led_pa1, led_pa2, led_pa3, led_pa4;
  logic led_sclk, led_latch, led_blank;
  logic frame_start;

  hub75_scan_driver #(
    .BASE_CYCLES(BASE),
    .DEADTIME(DT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .r0(r0), .g0(g0), .b0(b0),
    .r1(r1), .g1(g1), .b1(b1),
    .row(row), .col(col),
    .led_r0(led_r0), .led_g0(led_g0),
    .led_b0(led_b0), .led_r1(led_r1),
    .led_g1(led_g1), .led_b1(led_b1),
    .led_pa1(led_pa1), .led_pa2(led_pa2),
    .led_pa3(led_pa3), .led_pa4(led_pa4),
    .led_sclk(led_sclk), .led_latch(led_latch),
    .led_blank(led_blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [2:0] fb_r0[16][64], fb_g0[16][64];
  logic [2:0] fb_r1[16][64], fb_g1[16][64];
  logic [1:0] fb_b0[16][64], fb_b1[16][64];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   fs_q[$];
  bit   mon_on = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Framebuffer read model: data valid one cycle after address
  always @(negedge clk) begin
    r0 = fb_r0[row][col];
    g0 = fb_g0[row][col];
    b0 = fb_b0[row][col];
    r1 = fb_r1[row][col];
    g1 = fb_g1[row][col];
    b1 = fb_b1[row][col];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (frame_start) fs_q.push_back(cyc);

  function automatic int bitp(input int v, input int p);
    return (v >> p) & 1;
  endfunction

  function automatic int bext(input int b);
    return b * 2 + (b >> 1);
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 3; p++) begin
        e.row = r;
        e.plane = p;
        e.disp = BASE * (1 << p);
        for (int c = 0; c < 64; c++) begin
          e.r0[c] = 1'(bitp(int'(fb_r0[r][c]), p));
          e.g0[c] = 1'(bitp(int'(fb_g0[r][c]), p));
          e.b0[c] = 1'(bitp(bext(int'(fb_b0[r][c])), p));
          e.r1[c] = 1'(bitp(int'(fb_r1[r][c]), p));
          e.g1[c] = 1'(bitp(int'(fb_g1[r][c]), p));
          e.b1[c] = 1'(bitp(bext(int'(fb_b1[r][c])), p));
        end
        sb.push_back(e);
      end
  endtask

  // Monitor: assemble one transaction per display window
  logic [63:0] cr0, cg0, cb0, cr1, cg1, cb1;
  int   nsclk = 0, nlatch = 0, ndisp = 0;
  int   last_sclk = 0, lat_gap = 0, lat_pa = 0;
  logic prev_blank = 1;
  logic [3:0] prev_pa = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] cur_pa;
    if (mon_on) begin
      cur_pa = {led_pa4, led_pa3, led_pa2, led_pa1};
      if (cur_pa != prev_pa) chk("pa_blank", led_blank, 1);
      prev_pa = cur_pa;
      if (led_sclk) begin
        if (nsclk < 64) begin
          cr0[nsclk] = led_r0; cg0[nsclk] = led_g0;
          cb0[nsclk] = led_b0; cr1[nsclk] = led_r1;
          cg1[nsclk] = led_g1; cb1[nsclk] = led_b1;
        end
        nsclk++;
        last_sclk = cyc;
      end
      if (led_latch) begin
        nlatch++;
        lat_pa = int'(cur_pa);
        lat_gap = cyc - last_sclk;
        chk("latch_blank", led_blank, 1);
      end
      if (!led_blank) ndisp++;
      if (led_blank && !prev_blank) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got extra window");
        end else begin
          e = sb.pop_front();
          chk("sclk_edges", nsclk, 64);
          chk("latch_cnt", nlatch, 1);
          chk("latch_gap", lat_gap, PRE + 1);
          chk("row_sel", lat_pa, e.row);
          chk("disp_len", ndisp, e.disp);
          chk("bits_r0", cr0, e.r0);
          chk("bits_g0", cg0, e.g0);
          chk("bits_b0", cb0, e.b0);
          chk("bits_r1", cr1, e.r1);
          chk("bits_g1", cg1, e.g1);
          chk("bits_b1", cb1, e.b1);
        end
        nsclk = 0;
        nlatch = 0;
        ndisp = 0;
      end
      prev_blank = led_blank;
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_blank"}, led_blank, 1);
    chk({tag, "_sclk"}, led_sclk, 0);
    chk({tag, "_latch"}, led_latch, 0);
    chk({tag, "_rgb"},
        {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1}, 0);
    chk({tag, "_pa"},
        {led_pa4, led_pa3, led_pa2, led_pa1}, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    rst = 1;
    enable = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++) begin
        fb_r0[r][c] = 3'($urandom);
        fb_g0[r][c] = 3'($urandom);
        fb_b0[r][c] = 2'($urandom);
        fb_r1[r][c] = 3'($urandom);
        fb_g1[r][c] = 3'($urandom);
        fb_b1[r][c] = 2'($urandom);
      end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;
    repeat (2 + $urandom_range(0, 10)) @(negedge clk);
    chk("idle_blank", led_blank, 1);
    chk("idle_fs_cnt", fs_q.size(), 0);

    push_frame();
    push_frame();
    mon_on = 1;
    enable = 1;
    @(negedge clk);
    chk("fs_pulse", frame_start, 1);
    chk("fs_row", row, 0);
    chk("fs_col", col, 0);
    chk("fs_blank", led_blank, 1);
    @(negedge clk);
    chk("fs_width", frame_start, 0);

    for (int i = 0; i < 30000 && fs_q.size() < 2; i++)
      @(negedge clk);
    chk("second_frame_seen", fs_q.size(), 2);
    if (fs_q.size() >= 2)
      chk("frame_period", fs_q[1] - fs_q[0], FRAME);
    // Dropping enable mid-frame must not cut the frame short
    repeat ($urandom_range(1, 5000)) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 30000 && sb.size() > 0; i++)
      @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    repeat (20) @(negedge clk);
    chk("stop_fs_cnt", fs_q.size(), 2);
    chk("stop_blank", led_blank, 1);
    chk("stop_row", row, 0);
    chk("stop_col", col, 0);

    mon_on = 0;
    enable = 1;
    run = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      run = led_blank ? 0 : run + 1;
      if (run == 100) break;
    end
    chk("disp_100_found", run, 100);
    rst = 1;
    @(negedge clk);
    chk_idle_outputs("rst_disp");
    rst = 0;
    enable = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_blank", led_blank, 1);
    chk("post_rst_fs_cnt", fs_q.size(), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
